// File: rtl/alu_sequencer_pkg.sv
// Shared types for the 32-bit ALU sequencer: operation codes, external ALU
// select codes and the FSM state encoding.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpNot = 3'd5,
    OpInc = 3'd6,
    OpDec = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    SelAdd = 3'd0,
    SelSub = 3'd1,
    SelAnd = 3'd2,
    SelOr  = 3'd3,
    SelXor = 3'd4,
    SelNot = 3'd5,
    SelInc = 3'd6,
    SelDec = 3'd7
  } alu_sel_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLo   = 3'd1,
    StGap  = 3'd2,
    StHi   = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Runs a 32-bit operation as two 16-bit passes through an external ALU,
// with a mandatory enable-low gap so the ALU sees a fresh enable edge.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [15:0] alu_in_1,
  output logic [15:0] alu_in_2,
  output logic [2:0]  alu_select,
  output logic        alu_enable,
  output logic        alu_carry_in,
  input  logic [15:0] alu_data,
  input  logic        alu_carry_out,
  output logic [31:0] result,
  output logic        carry,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] GapLast = 2'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  gap_q, gap_d;
  op_e         op_q;
  logic [31:0] a_q, b_q;
  logic [15:0] lo_q;
  logic        c_lo_q;
  logic [31:0] result_q;
  logic        carry_q, zero_q;
  logic        is_arith, hi_phase;
  logic [15:0] b_half;

  assign is_arith = op_q inside {OpAdd, OpSub, OpInc, OpDec};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      lo_q     <= '0;
      c_lo_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (state_q == StIdle && start) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op_e'(op);
      end
      if (state_q == StLo) begin
        lo_q   <= alu_data;
        c_lo_q <= alu_carry_out;
      end
      // Both halves commit together so the visible result holds until completion.
      if (state_q == StHi) begin
        result_q <= {alu_data, lo_q};
        carry_q  <= is_arith ? alu_carry_out : 1'b0;
        zero_q   <= ({alu_data, lo_q} == 32'd0);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLo;
      StLo: begin
        state_d = StGap;
        gap_d   = '0;
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StHi;
        else                  gap_d   = gap_q + 2'd1;
      end
      StHi:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_enable   = (state_q == StLo) || (state_q == StHi);
    hi_phase     = (state_q == StHi);
    b_half       = hi_phase ? b_q[31:16] : b_q[15:0];
    alu_in_1     = '0;
    alu_in_2     = '0;
    alu_select   = SelAdd;
    alu_carry_in = 1'b0;
    if (alu_enable) begin
      alu_in_1 = hi_phase ? a_q[31:16] : a_q[15:0];
      unique case (op_q)
        OpAdd: begin
          alu_in_2     = b_half;
          alu_carry_in = hi_phase ? c_lo_q : 1'b0;
        end
        OpSub: begin
          alu_in_2     = ~b_half;
          alu_carry_in = hi_phase ? c_lo_q : 1'b1;
        end
        OpInc: begin
          alu_in_2     = 16'h0000;
          alu_carry_in = hi_phase ? c_lo_q : 1'b1;
        end
        OpDec: begin
          alu_in_2     = 16'hFFFF;
          alu_carry_in = hi_phase ? c_lo_q : 1'b0;
        end
        OpAnd: begin
          alu_select = SelAnd;
          alu_in_2   = b_half;
        end
        OpOr: begin
          alu_select = SelOr;
          alu_in_2   = b_half;
        end
        OpXor: begin
          alu_select = SelXor;
          alu_in_2   = b_half;
        end
        OpNot: begin
          alu_select = SelNot;
          alu_in_2   = b_half;
        end
        default: alu_in_2 = '0;
      endcase
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 16-bit ALU and a
// scoreboard of expected 32-bit results.
module tb_alu_sequencer;

  localparam int unsigned GapCycles = 1;
  localparam int unsigned Latency   = 3 + GapCycles;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic        carry;
    logic        zero;
  } exp_t;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [15:0] alu_in_1, alu_in_2, alu_data;
  logic [2:0]  alu_select;
  logic        alu_enable, alu_carry_in, alu_carry_out;
  logic [31:0] result;
  logic        carry, zero, busy, done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_sequencer #(.GAP_CYCLES(GapCycles)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .alu_in_1     (alu_in_1),
    .alu_in_2     (alu_in_2),
    .alu_select   (alu_select),
    .alu_enable   (alu_enable),
    .alu_carry_in (alu_carry_in),
    .alu_data     (alu_data),
    .alu_carry_out(alu_carry_out),
    .result       (result),
    .carry        (carry),
    .zero         (zero),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 16-bit ALU: select 0 adds with carry, 2..5 are bitwise ops.
  always_comb begin
    alu_data      = '0;
    alu_carry_out = 1'b0;
    if (alu_enable) begin
      case (alu_select)
        3'd0: {alu_carry_out, alu_data} = {1'b0, alu_in_1} + {1'b0, alu_in_2}
                                          + {16'd0, alu_carry_in};
        3'd2: alu_data = alu_in_1 & alu_in_2;
        3'd3: alu_data = alu_in_1 | alu_in_2;
        3'd4: alu_data = alu_in_1 ^ alu_in_2;
        3'd5: alu_data = ~alu_in_1;
        default: alu_data = '0;
      endcase
    end
  end

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input string tag);
    exp_t e;
    logic [32:0] s;
    case (o)
      3'd0: s = {1'b0, x} + {1'b0, y};
      3'd1: s = {1'b0, x} + {1'b0, ~y} + 33'd1;
      3'd2: s = {1'b0, x & y};
      3'd3: s = {1'b0, x | y};
      3'd4: s = {1'b0, x ^ y};
      3'd5: s = {1'b0, ~x};
      3'd6: s = {1'b0, x} + 33'd1;
      default: s = {1'b0, x} + 33'h0_FFFF_FFFF;
    endcase
    e.tag    = tag;
    e.result = s[31:0];
    e.carry  = s[32];
    e.zero   = (s[31:0] == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".result"}, result, 32'd0);
    check({tag, ".carry"}, {31'd0, carry}, 32'd0);
    check({tag, ".zero"}, {31'd0, zero}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".done"}, {31'd0, done}, 32'd0);
    check({tag, ".alu_enable"}, {31'd0, alu_enable}, 32'd0);
    check({tag, ".alu_drive"}, {alu_in_1 | alu_in_2, 12'd0, alu_select, alu_carry_in}, 32'd0);
  endtask

  // Issue one op; optionally re-pulse start while in LO, which must be ignored.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag, input bit poke_lo);
    exp_t       e;
    int         cyc, drv_bad, extra;
    logic [7:0] en_seq;
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(model(o, x, y, tag));
    @(negedge clk);
    start   = 1'b0;
    a       = $urandom;
    b       = $urandom;
    op      = 3'($urandom_range(0, 7));
    cyc     = 1;
    en_seq  = '0;
    drv_bad = 0;
    while (!done && cyc < 20) begin
      en_seq = {en_seq[6:0], alu_enable};
      if (!alu_enable && ({alu_in_1, alu_in_2, alu_select, alu_carry_in} != '0)) drv_bad++;
      start = (poke_lo && cyc == 1);
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    check({tag, ".latency"}, cyc, Latency);
    check({tag, ".enable_seq"}, {24'd0, en_seq}, 32'b101);
    check({tag, ".drive_when_off"}, drv_bad, 0);
    check({tag, ".busy_in_done"}, {31'd0, busy}, 32'd1);
    check({e.tag, ".result"}, result, e.result);
    check({e.tag, ".carry"}, {31'd0, carry}, {31'd0, e.carry});
    check({e.tag, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
    @(negedge clk);
    check({tag, ".hold"}, result, e.result);
    extra = 0;
    repeat (3) begin
      if (busy || done) extra++;
      @(negedge clk);
    end
    check({tag, ".quiet_after_done"}, extra, 0);
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    run_op(3'd0, 32'h0000_FFFF, 32'h0000_0001, "add_carry16", 1'b0);
    run_op(3'd1, 32'h0001_0000, 32'h0000_0001, "sub_borrow16", 1'b0);
    run_op(3'd1, 32'h0000_0000, 32'h0000_0001, "sub_wrap", 1'b0);
    run_op(3'd6, 32'hFFFF_FFFF, 32'h1234_5678, "inc_wrap", 1'b0);
    run_op(3'd7, 32'h0000_0000, 32'h0000_0000, "dec_wrap", 1'b0);
    run_op(3'd7, 32'h0001_0000, 32'h0000_0000, "dec_borrow", 1'b0);
    run_op(3'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, "xor", 1'b0);
    run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, "and", 1'b0);
    run_op(3'd3, 32'h8000_0001, 32'h0000_F000, "or", 1'b0);
    run_op(3'd5, 32'h00FF_FF00, 32'h0000_0000, "not", 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap", 1'b0);
    run_op(3'd0, 32'h1234_5678, 32'h1111_1111, "add_poke_lo", 1'b1);

    // Reset during GAP discards the op with no done pulse.
    @(negedge clk);
    op    = 3'd0;
    a     = 32'h7777_7777;
    b     = 32'h1111_1111;
    start = 1'b1;
    sb.push_back(model(3'd0, a, b, "aborted"));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("gap.enable_low", {31'd0, alu_enable}, 32'd0);
    check("gap.busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_idle("reset_in_gap");
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (8) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("reset_in_gap.no_done", dones, 0);

    run_op(3'd1, 32'h8000_0000, 32'h0000_0001, "after_reset", 1'b0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 1, count of enable-low cycles between the two ALU phases (1..3).
REQ-002 clk  input  1  rising-edge clock, the single clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request, sampled only in IDLE.
REQ-005 op  input  3  32-bit operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 INC, 7 DEC.
REQ-006 a, b  input  32  operands, captured on accepted start.
REQ-007 alu_in_1, alu_in_2  output  16  operand halves driven to the 16-bit ALU.
REQ-008 alu_select  output  3  ALU operation code.
REQ-009 alu_enable  output  1  ALU bus-drive/compute enable.
REQ-010 alu_carry_in  output  1  ALU carry input.
REQ-011 alu_data  input  16  ALU result bus; alu_carry_out  input  1  ALU carry.
REQ-012 result  output  32  final result; carry  output  1; zero  output  1.
REQ-013 busy  output  1  high from accept through DONE; done  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states IDLE, LO, GAP, HI, DONE; IDLE -start-> LO -> GAP (GAP_CYCLES cycles) -> HI -> DONE -> IDLE.
REQ-015 Start accepted only in IDLE; start while busy is ignored, not queued.
REQ-016 On accept, a, b, op are registered; later input changes have no effect.
REQ-017 alu_enable high exactly in LO and HI, low in IDLE, GAP, DONE (ALU computes only on an enable rising edge, so the gap is mandatory).
REQ-018 LO drives low halves, HI drives high halves; alu_data and alu_carry_out are captured at the clock edge ending LO (into result[15:0], c_lo) and HI (into result[31:16], final carry).
REQ-019 ADD: select 0; carry_in 0 in LO, c_lo in HI; in_2 = b half.
REQ-020 SUB: select 0 with in_2 = ~b half; carry_in 1 in LO, c_lo in HI; carry = NOT borrow.
REQ-021 INC: select 0, in_2 = 0x0000, carry_in 1 in LO, c_lo in HI.
REQ-022 DEC: select 0, in_2 = 0xFFFF, carry_in 0 in LO, c_lo in HI.
REQ-023 AND/OR/XOR/NOT: select 2/3/4/5 both phases, carry_in 0; final carry forced 0.
REQ-024 zero = (32-bit result == 0), updated with result in HI capture.
REQ-025 Latency start-to-done = 3 + GAP_CYCLES cycles; total busy = that value; done high one cycle in DONE.
REQ-026 result, carry, zero hold their values from DONE until next completion.
REQ-027 alu_in_1, alu_in_2, alu_select, alu_carry_in are 0 whenever alu_enable is low.
REQ-028 Arithmetic wraps modulo 2^32; overflow only reported via carry.

Reset
REQ-029 reset asserted at any time forces IDLE immediately, alu_enable 0, busy 0, done 0, result 0, carry 0, zero 0, all ALU drive outputs 0.
REQ-030 Operation in progress at reset is discarded; no done pulse follows.
REQ-031 First start is accepted on the first rising clk edge after reset deasserts.

Structure
REQ-032 Shared package holds 32-bit op codes (ADD..DEC), ALU select codes 0..7, and FSM state encoding.
REQ-033 No sub-module; ALU is instantiated externally; bench instantiates alu plus alu_sequencer.

Verification
REQ-034 ADD a=0x0000FFFF, b=0x00000001 -> result 0x00010000, carry 0, zero 0, done at cycle 4 (GAP_CYCLES=1).
REQ-035 SUB a=0x00010000, b=0x00000001 -> result 0x0000FFFF, carry 1; SUB a=0, b=1 -> 0xFFFFFFFF, carry 0.
REQ-036 INC a=0xFFFFFFFF -> result 0, carry 1, zero 1; DEC a=0 -> 0xFFFFFFFF, carry 0.
REQ-037 XOR a=0xA5A5A5A5, b=0xFFFF0000 -> 0x5A5AA5A5, carry 0; check alu_enable low for exactly GAP_CYCLES between phases.
REQ-038 start pulsed again during LO -> ignored, single done; reset asserted during GAP -> outputs zero immediately, no done.
